// File: rtl/spi_slave_rx.sv
// Receive endpoint for the 3-wire SPI link: oversamples CS/SCLK/DATA with clk,
// deserialises MSB-first frames and hands each word over under a valid/ack handshake.
module spi_slave_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  localparam int CW = $clog2(DATA_WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  spi_CS,
  input  logic                  spi_sclk,
  input  logic                  spiData,
  input  logic                  dataAck,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataValid,
  output logic                  overrun,
  output logic                  frameErr,
  output logic [CW-1:0]         counter
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    WAIT_CS = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] cs_sync_reg;
  logic [SYNC_STAGES-1:0] sclk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic [SYNC_STAGES-1:0] prime_reg;
  logic                   cs_prev_reg;
  logic                   sclk_prev_reg;

  logic cs_synced;
  logic sclk_synced;
  logic data_synced;
  logic cs_fall;
  logic cs_rise;
  logic sclk_rise;
  logic cs_from_pin;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] shift_reg, shift_next;
  logic [DATA_WIDTH-1:0] dout_reg, dout_next;
  logic [CW-1:0]         count_reg, count_next;
  logic                  valid_reg, valid_next;
  logic                  overrun_reg, overrun_next;
  logic                  ferr_reg, ferr_next;
  logic                  armed_reg, armed_next;
  logic [DATA_WIDTH-1:0] shifted;

  // Synchroniser chains; CS idles high so its stages come out of reset at 1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_reg   <= '1;
      sclk_sync_reg <= '0;
      data_sync_reg <= '0;
      prime_reg     <= '0;
      cs_prev_reg   <= 1'b1;
      sclk_prev_reg <= 1'b0;
    end else begin
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], spi_CS};
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_sclk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], spiData};
      prime_reg     <= {prime_reg[SYNC_STAGES-2:0], 1'b1};
      cs_prev_reg   <= cs_synced;
      sclk_prev_reg <= sclk_synced;
    end
  end

  assign cs_synced   = cs_sync_reg[SYNC_STAGES-1];
  assign sclk_synced = sclk_sync_reg[SYNC_STAGES-1];
  assign data_synced = data_sync_reg[SYNC_STAGES-1];
  assign cs_fall     = cs_prev_reg & ~cs_synced;
  assign cs_rise     = ~cs_prev_reg & cs_synced;
  assign sclk_rise   = ~sclk_prev_reg & sclk_synced;
  // Once the chain has flushed its reset value, cs_synced reflects the real pin.
  assign cs_from_pin = prime_reg[SYNC_STAGES-1];
  assign shifted     = {shift_reg[DATA_WIDTH-2:0], data_synced};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      dout_reg    <= '0;
      count_reg   <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
      ferr_reg    <= 1'b0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      shift_reg   <= shift_next;
      dout_reg    <= dout_next;
      count_reg   <= count_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
      ferr_reg    <= ferr_next;
      armed_reg   <= armed_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    shift_next   = shift_reg;
    dout_next    = dout_reg;
    count_next   = count_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    ferr_next    = 1'b0;
    // A CS low at reset release must see a genuine high before a frame may start.
    armed_next   = armed_reg | (cs_from_pin & cs_synced);

    if (valid_reg && dataAck) begin
      valid_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (cs_fall && armed_reg) begin
          shift_next = '0;
          count_next = '0;
          state_next = SHIFT;
        end
      end

      SHIFT: begin
        if (sclk_rise) begin
          shift_next = shifted;
          count_next = count_reg + CW'(1);
          if (count_reg == CW'(DATA_WIDTH - 1)) begin
            // Completed word overrides a same-cycle acknowledge.
            dout_next    = shifted;
            valid_next   = 1'b1;
            overrun_next = valid_reg & ~dataAck;
            state_next   = cs_rise ? IDLE : WAIT_CS;
          end else if (cs_rise) begin
            ferr_next  = 1'b1;
            state_next = IDLE;
          end
        end else if (cs_rise) begin
          ferr_next  = (count_reg != '0);
          state_next = IDLE;
        end
      end

      WAIT_CS: begin
        if (cs_rise) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dataOut   = dout_reg;
  assign dataValid = valid_reg;
  assign overrun   = overrun_reg;
  assign frameErr  = ferr_reg;
  assign counter   = count_reg;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: drives SPI frames bit by bit and checks the
// parallel word, handshake, overrun/frame-error pulses and counter.
module tb_spi_slave_rx;

  logic        clk;
  logic        reset;
  logic        spi_CS;
  logic        spi_sclk;
  logic        spiData;
  logic        dataAck;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        overrun;
  logic        frameErr;
  logic [4:0]  counter;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;

  spi_slave_rx dut (
    .clk       (clk),
    .reset     (reset),
    .spi_CS    (spi_CS),
    .spi_sclk  (spi_sclk),
    .spiData   (spiData),
    .dataAck   (dataAck),
    .dataOut   (dataOut),
    .dataValid (dataValid),
    .overrun   (overrun),
    .frameErr  (frameErr),
    .counter   (counter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters: a pulse wider than one clk is counted more than once.
  always @(negedge clk) begin
    if (overrun)  ovr_cnt++;
    if (frameErr) fe_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic spi_bit(input logic b);
    spiData = b;
    tick(4);
    spi_sclk = 1'b1;
    tick(4);
    spi_sclk = 1'b0;
  endtask

  // Sends the n low bits of w, MSB first, inside one CS-low window.
  task automatic send_bits(input logic [31:0] w, input int n);
    spi_CS = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) spi_bit(w[i]);
    tick(4);
    spi_CS = 1'b1;
    tick(6);
  endtask

  task automatic ack();
    dataAck = 1'b1;
    tick(1);
    dataAck = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    reset    = 1'b1;
    spi_CS   = 1'b1;
    spi_sclk = 1'b0;
    spiData  = 1'b0;
    dataAck  = 1'b0;
    tick(3);
    chk("rst_dataOut", 32'(dataOut), 32'h0);
    chk("rst_dataValid", 32'(dataValid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frameErr", 32'(frameErr), 32'h0);
    chk("rst_counter", 32'(counter), 32'h0);
    reset = 1'b0;
    tick(5);

    // Basic receive with exact dataValid latency on the 16th bit
    w = 16'hA569;
    spi_CS = 1'b0;
    tick(4);
    for (int i = 15; i >= 1; i--) spi_bit(w[i]);
    spiData = w[0];
    tick(4);
    spi_sclk = 1'b1;
    tick(2);
    chk("basic_valid_early", 32'(dataValid), 32'h0);
    tick(1);
    chk("basic_valid_lat3", 32'(dataValid), 32'h1);
    chk("basic_data1", 32'(dataOut), 32'hA569);
    tick(3);
    spi_sclk = 1'b0;
    tick(4);
    spi_CS = 1'b1;
    tick(6);
    chk("basic_counter16", 32'(counter), 32'd16);
    ack();
    chk("basic_ack_clears", 32'(dataValid), 32'h0);
    chk("basic_data_held", 32'(dataOut), 32'hA569);
    send_bits(32'h2563, 16);
    chk("basic_data2", 32'(dataOut), 32'h2563);
    chk("basic_valid2", 32'(dataValid), 32'h1);
    chk("basic_no_ovr", 32'(ovr_cnt), 32'd0);
    chk("basic_no_fe", 32'(fe_cnt), 32'd0);
    ack();

    // Overrun: second frame lands on an unacknowledged word
    send_bits(32'h9B63, 16);
    chk("ovr_first_none", 32'(ovr_cnt), 32'd0);
    send_bits(32'h6A61, 16);
    chk("ovr_single_pulse", 32'(ovr_cnt), 32'd1);
    chk("ovr_data", 32'(dataOut), 32'h6A61);
    chk("ovr_valid", 32'(dataValid), 32'h1);
    ack();

    // Aborted frame after 7 bits of A265 (top 7 bits = 7'b1010001)
    fe_cnt = 0;
    ovr_cnt = 0;
    send_bits(32'h51, 7);
    chk("abort_fe_pulse", 32'(fe_cnt), 32'd1);
    chk("abort_counter7", 32'(counter), 32'd7);
    chk("abort_data_kept", 32'(dataOut), 32'h6A61);
    chk("abort_valid_kept", 32'(dataValid), 32'h0);
    send_bits(32'h7564, 16);
    chk("abort_next_data", 32'(dataOut), 32'h7564);
    chk("abort_next_valid", 32'(dataValid), 32'h1);
    chk("abort_next_no_fe", 32'(fe_cnt), 32'd1);
    ack();

    // Extra clocks: 20 pulses, last 4 are junk
    fe_cnt = 0;
    send_bits(32'hA569A, 20);
    chk("extra_data", 32'(dataOut), 32'hA569);
    chk("extra_counter_sat", 32'(counter), 32'd16);
    chk("extra_no_fe", 32'(fe_cnt), 32'd0);
    chk("extra_valid", 32'(dataValid), 32'h1);

    // Reset mid-frame with CS still low; the rest of that window is ignored
    w = 16'h2563;
    spi_CS = 1'b0;
    tick(4);
    for (int i = 15; i >= 7; i--) spi_bit(w[i]);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    chk("mrst_counter", 32'(counter), 32'h0);
    tick(1);
    for (int i = 6; i >= 0; i--) spi_bit(w[i]);
    tick(4);
    spi_CS = 1'b1;
    tick(6);
    chk("mrst_dataOut", 32'(dataOut), 32'h0);
    chk("mrst_valid", 32'(dataValid), 32'h0);
    chk("mrst_counter_after", 32'(counter), 32'h0);
    send_bits(32'h2563, 16);
    chk("mrst_next_data", 32'(dataOut), 32'h2563);
    chk("mrst_next_valid", 32'(dataValid), 32'h1);

    // Ack collides with completion of 9B63 while 2563 is still pending
    ovr_cnt = 0;
    w = 16'h9B63;
    spi_CS = 1'b0;
    tick(4);
    for (int i = 15; i >= 1; i--) spi_bit(w[i]);
    spiData = w[0];
    tick(4);
    spi_sclk = 1'b1;
    tick(2);
    dataAck = 1'b1;
    tick(1);
    dataAck = 1'b0;
    chk("coll_valid", 32'(dataValid), 32'h1);
    chk("coll_data", 32'(dataOut), 32'h9B63);
    tick(3);
    spi_sclk = 1'b0;
    tick(4);
    spi_CS = 1'b1;
    tick(6);
    chk("coll_no_ovr", 32'(ovr_cnt), 32'd0);
    chk("coll_valid_held", 32'(dataValid), 32'h1);
    ack();
    chk("coll_final_ack", 32'(dataValid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
